ddmtd_tag_pairer: RTL and testbench
===================================

Name: ddmtd_tag_pairer

Overview:
- Consumer end of the deglitcher tag interface (tag value + 1-cycle valid pulse) in the clk_ddmtd_i domain.
- Takes tag streams from two deglitchers: A = reference clock, B = measured clock.
- Pairs each A edge with the matching B edge inside a programmable window and emits the modular phase difference B−A.
- Also emits the A beat period, and counts unpaired (orphan) tags for link-health monitoring.

Parameters:
- COUNTER_BIT_WIDTH, 16, width of the tags, phase and period outputs.
- AVG_LOG2, 4, log2 of the averaging depth; used only when DDMTD_PHASE_AVG_EN is defined.

Ports:
- clk_ddmtd_i  in  1  DDMTD sampling clock; only clock.
- rst_ddmtdclk_i  in  1  asynchronous, active-high reset.
- tag_a_i  in  COUNTER_BIT_WIDTH  reference-channel tag.
- tag_a_p_i  in  1  tag_a_i valid, 1-cycle pulse.
- tag_b_i  in  COUNTER_BIT_WIDTH  measured-channel tag.
- tag_b_p_i  in  1  tag_b_i valid, 1-cycle pulse.
- pair_window_i  in  COUNTER_BIT_WIDTH  maximum wait, in cycles after capture, for the partner tag.
- phase_o  out  COUNTER_BIT_WIDTH  (tag_b − tag_a) mod 2^COUNTER_BIT_WIDTH.
- phase_p_o  out  1  phase_o valid pulse.
- period_o  out  COUNTER_BIT_WIDTH  difference between consecutive A tags, modular.
- period_p_o  out  1  period_o valid pulse.
- orphan_cnt_o  out  16  saturating count of discarded tags.
- avg_phase_o  out  COUNTER_BIT_WIDTH  averaged phase (optional feature).
- avg_phase_p_o  out  1  avg_phase_o valid pulse (optional feature).

Behaviour:
- Reset: all outputs 0, state IDLE, stored tags 0, window timer 0, period history invalid. Asserting reset mid-operation abandons any pending pair immediately; nothing is emitted for it.
- All subtraction is modular, with no sign handling. Wrap-around is exact: B tag 0x0003 minus A tag 0xFFFE gives phase 0x0005.
- Output latency: phase_o/phase_p_o are registered 1 cycle after the cycle in which the completing pulse is seen. period_o/period_p_o are registered 1 cycle after the A pulse.
- Period: every A pulse after the first one since reset updates period_o = tag_a − previous tag_a. This applies whether or not that A pulse gets paired.
- IDLE:
  - A and B pulses in the same cycle: phase = tag_b_i − tag_a_i; stay in IDLE.
  - A pulse only: store tag_a_i, timer←0, go to HAVE_A.
  - B pulse only: store tag_b_i, timer←0, go to HAVE_B.
- HAVE_A (checked in priority order):
  - B pulse: phase = tag_b_i − stored_a. If an A pulse arrives in the same cycle, store it, timer←0, stay in HAVE_A; otherwise go to IDLE.
  - A pulse only: previous stored_a is an orphan (orphan_cnt +1). Store the new tag, timer←0, stay in HAVE_A.
  - timer ≥ pair_window_i: orphan +1, go to IDLE.
  - Otherwise: timer +1.
- HAVE_B: mirror image of HAVE_A with the roles of A and B swapped. phase = stored_b − tag_a_i.
- Window semantics:
  - A partner arriving in the same cycle as the timeout check wins over the timeout.
  - With pair_window_i = 0, the partner must arrive on the first cycle after capture.
- orphan_cnt_o saturates at 0xFFFF and is cleared only by reset.
- Illegal state encoding: go to IDLE.

Optional Feature:
- Macro: DDMTD_PHASE_AVG_EN.
- Defined:
  - Each emitted phase is sign-extended (treated as two's complement) into a (COUNTER_BIT_WIDTH+AVG_LOG2)-bit accumulator.
  - After 2^AVG_LOG2 samples, avg_phase_o = accumulator arithmetic-shifted right by AVG_LOG2 (truncated) and avg_phase_p_o pulses for 1 cycle. This happens 1 cycle after the last sample's phase_p_o.
  - The accumulator and sample count are then cleared.
- Not defined: avg_phase_o and avg_phase_p_o are constant 0 and no accumulator logic is built.

Test Plan:
- Simultaneous pulses: A=0x0100, B=0x0140 in the same cycle → next cycle phase_o=0x0040, phase_p_o high for exactly 1 cycle; orphan_cnt_o=0.
- Wrap and ordering: window=8; A=0xFFFE, then B=0x0003 3 cycles later → phase_o=0x0005. B=0x0010, then A=0x0020 2 cycles later → phase_o=0xFFF0.
- Timeout: window=4; A pulse, no B for 10 cycles → no phase_p_o, orphan_cnt_o=1, state IDLE. A B pulse arriving exactly at the timeout-check cycle pairs instead, with orphan_cnt_o=0.
- Double A plus period: A=0x1000, A=0x1800 before any B, then B=0x1810 → orphan_cnt_o=1, phase_o=0x0010, period_o=0x0800.
- Reset mid-pair: A captured, reset asserted asynchronously between clock edges → all outputs 0 immediately; a B pulse after release goes to HAVE_B and no phase is emitted for it.
- DDMTD_PHASE_AVG_EN with AVG_LOG2=2: phases 0x0004, 0x0008, 0xFFFC, 0x0000 → avg_phase_o=0x0002, one avg_phase_p_o pulse.

Source files
------------

// File: rtl/ddmtd_tag_pairer.sv
// ---------------------------------------------------------------------------
// ddmtd_tag_pairer
//
// Pairs DDMTD deglitcher tags from a reference channel (A) and a measured
// channel (B) in the clk_ddmtd_i domain. Each A edge is matched with the
// B edge that arrives within a programmable window, and the modular phase
// difference (tag_b - tag_a) is emitted. The A beat period (difference
// between consecutive A tags) is also emitted. Tags that never find a
// partner are counted in a saturating orphan counter.
//
// Optional build feature (macro DDMTD_PHASE_AVG_EN):
//   When defined, emitted phases are treated as two's complement, summed
//   over 2^AVG_LOG2 samples and the arithmetic mean is emitted on
//   avg_phase_o / avg_phase_p_o. When undefined, both outputs are 0.
//
// Ports:
//   clk_ddmtd_i     DDMTD sampling clock (only clock)
//   rst_ddmtdclk_i  asynchronous active-high reset
//   tag_a_i/_p_i    reference tag and 1-cycle valid pulse
//   tag_b_i/_p_i    measured tag and 1-cycle valid pulse
//   pair_window_i   max wait (cycles after capture) for the partner tag
//   phase_o/_p_o    (tag_b - tag_a) mod 2^W and valid pulse
//   period_o/_p_o   consecutive A tag difference and valid pulse
//   orphan_cnt_o    saturating count of discarded tags
//   avg_phase_o/_p_o averaged phase and valid pulse (optional feature)
// ---------------------------------------------------------------------------
module ddmtd_tag_pairer #(
    parameter int unsigned COUNTER_BIT_WIDTH = 16,
    parameter int unsigned AVG_LOG2          = 4
) (
    input  logic                         clk_ddmtd_i,
    input  logic                         rst_ddmtdclk_i,
    input  logic [COUNTER_BIT_WIDTH-1:0] tag_a_i,
    input  logic                         tag_a_p_i,
    input  logic [COUNTER_BIT_WIDTH-1:0] tag_b_i,
    input  logic                         tag_b_p_i,
    input  logic [COUNTER_BIT_WIDTH-1:0] pair_window_i,
    output logic [COUNTER_BIT_WIDTH-1:0] phase_o,
    output logic                         phase_p_o,
    output logic [COUNTER_BIT_WIDTH-1:0] period_o,
    output logic                         period_p_o,
    output logic [15:0]                  orphan_cnt_o,
    output logic [COUNTER_BIT_WIDTH-1:0] avg_phase_o,
    output logic                         avg_phase_p_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        HAVE_B = 2'b10
    } state_t;

    state_t                         state_q, state_d;
    logic [COUNTER_BIT_WIDTH-1:0]   stored_a_q, stored_a_d;
    logic [COUNTER_BIT_WIDTH-1:0]   stored_b_q, stored_b_d;
    logic [COUNTER_BIT_WIDTH-1:0]   timer_q, timer_d;
    logic [COUNTER_BIT_WIDTH-1:0]   phase_q, phase_d;
    logic                           phase_p_q, phase_p_d;
    logic [COUNTER_BIT_WIDTH-1:0]   period_q, period_d;
    logic                           period_p_q, period_p_d;
    logic [COUNTER_BIT_WIDTH-1:0]   prev_a_q, prev_a_d;
    logic                           prev_a_vld_q, prev_a_vld_d;
    logic [15:0]                    orphan_q, orphan_d;
    logic                           orphan_inc;

    // ------------------------------------------------------------------
    // Pairing FSM, period tracking and orphan accounting
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        stored_a_d   = stored_a_q;
        stored_b_d   = stored_b_q;
        timer_d      = timer_q;
        phase_d      = phase_q;
        phase_p_d    = 1'b0;
        period_d     = period_q;
        period_p_d   = 1'b0;
        prev_a_d     = prev_a_q;
        prev_a_vld_d = prev_a_vld_q;
        orphan_inc   = 1'b0;

        // Period runs independently of pairing: every A after the first.
        if (tag_a_p_i) begin
            prev_a_d     = tag_a_i;
            prev_a_vld_d = 1'b1;
            if (prev_a_vld_q) begin
                period_d   = tag_a_i - prev_a_q;
                period_p_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (tag_a_p_i && tag_b_p_i) begin
                    phase_d   = tag_b_i - tag_a_i;
                    phase_p_d = 1'b1;
                end else if (tag_a_p_i) begin
                    stored_a_d = tag_a_i;
                    timer_d    = '0;
                    state_d    = HAVE_A;
                end else if (tag_b_p_i) begin
                    stored_b_d = tag_b_i;
                    timer_d    = '0;
                    state_d    = HAVE_B;
                end
            end

            HAVE_A: begin
                // Partner is checked before the timeout so a partner on
                // the timeout cycle still pairs.
                if (tag_b_p_i) begin
                    phase_d   = tag_b_i - stored_a_q;
                    phase_p_d = 1'b1;
                    if (tag_a_p_i) begin
                        stored_a_d = tag_a_i;
                        timer_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tag_a_p_i) begin
                    orphan_inc = 1'b1;
                    stored_a_d = tag_a_i;
                    timer_d    = '0;
                end else if (timer_q >= pair_window_i) begin
                    orphan_inc = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + COUNTER_BIT_WIDTH'(1);
                end
            end

            HAVE_B: begin
                if (tag_a_p_i) begin
                    phase_d   = stored_b_q - tag_a_i;
                    phase_p_d = 1'b1;
                    if (tag_b_p_i) begin
                        stored_b_d = tag_b_i;
                        timer_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tag_b_p_i) begin
                    orphan_inc = 1'b1;
                    stored_b_d = tag_b_i;
                    timer_d    = '0;
                end else if (timer_q >= pair_window_i) begin
                    orphan_inc = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + COUNTER_BIT_WIDTH'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (orphan_inc && (orphan_q != '1)) begin
            orphan_d = orphan_q + 16'd1;
        end else begin
            orphan_d = orphan_q;
        end
    end

    always_ff @(posedge clk_ddmtd_i or posedge rst_ddmtdclk_i) begin
        if (rst_ddmtdclk_i) begin
            state_q      <= IDLE;
            stored_a_q   <= '0;
            stored_b_q   <= '0;
            timer_q      <= '0;
            phase_q      <= '0;
            phase_p_q    <= 1'b0;
            period_q     <= '0;
            period_p_q   <= 1'b0;
            prev_a_q     <= '0;
            prev_a_vld_q <= 1'b0;
            orphan_q     <= '0;
        end else begin
            state_q      <= state_d;
            stored_a_q   <= stored_a_d;
            stored_b_q   <= stored_b_d;
            timer_q      <= timer_d;
            phase_q      <= phase_d;
            phase_p_q    <= phase_p_d;
            period_q     <= period_d;
            period_p_q   <= period_p_d;
            prev_a_q     <= prev_a_d;
            prev_a_vld_q <= prev_a_vld_d;
            orphan_q     <= orphan_d;
        end
    end

    assign phase_o      = phase_q;
    assign phase_p_o    = phase_p_q;
    assign period_o     = period_q;
    assign period_p_o   = period_p_q;
    assign orphan_cnt_o = orphan_q;

    // ------------------------------------------------------------------
    // Optional phase averaging
    // ------------------------------------------------------------------
`ifdef DDMTD_PHASE_AVG_EN
    localparam int unsigned ACC_W = COUNTER_BIT_WIDTH + AVG_LOG2;

    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [AVG_LOG2-1:0]          cnt_q, cnt_d;
    logic [COUNTER_BIT_WIDTH-1:0] avg_q, avg_d;
    logic                         avg_p_q, avg_p_d;
    logic [ACC_W-1:0]             sample_ext;
    logic [ACC_W-1:0]             acc_sum;

    // Samples are taken from the registered phase, so the average pulse
    // lands one cycle after the last sample's phase_p_o.
    always_comb begin
        sample_ext = {{AVG_LOG2{phase_q[COUNTER_BIT_WIDTH-1]}}, phase_q};
        acc_sum    = acc_q + sample_ext;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        avg_d      = avg_q;
        avg_p_d    = 1'b0;
        if (phase_p_q) begin
            if (cnt_q == '1) begin
                avg_d   = COUNTER_BIT_WIDTH'($signed(acc_sum) >>> AVG_LOG2);
                avg_p_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk_ddmtd_i or posedge rst_ddmtdclk_i) begin
        if (rst_ddmtdclk_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            avg_p_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            avg_p_q <= avg_p_d;
        end
    end

    assign avg_phase_o   = avg_q;
    assign avg_phase_p_o = avg_p_q;
`else
    // AVG_LOG2 only shapes the averaging path; without it nothing is built.
    if (AVG_LOG2 == 0) begin : g_no_avg
    end

    assign avg_phase_o   = '0;
    assign avg_phase_p_o = 1'b0;
`endif

endmodule

// File: tb/tb_ddmtd_tag_pairer.sv
// ---------------------------------------------------------------------------
// tb_ddmtd_tag_pairer
//
// Directed bench for ddmtd_tag_pairer. Inputs change on the falling edge,
// the DUT captures on the rising edge, and outputs are checked on the
// following falling edge. Optional averaging checks run when
// DDMTD_PHASE_AVG_EN is defined.
// ---------------------------------------------------------------------------
module tb_ddmtd_tag_pairer;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  tag_a = '0;
    logic          tag_a_p = 1'b0;
    logic [W-1:0]  tag_b = '0;
    logic          tag_b_p = 1'b0;
    logic [W-1:0]  window = 16'd8;
    logic [W-1:0]  phase;
    logic          phase_p;
    logic [W-1:0]  period;
    logic          period_p;
    logic [15:0]   orphan_cnt;
    logic [W-1:0]  avg_phase;
    logic          avg_phase_p;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ddmtd_tag_pairer #(
        .COUNTER_BIT_WIDTH(W),
        .AVG_LOG2         (2)
    ) dut (
        .clk_ddmtd_i   (clk),
        .rst_ddmtdclk_i(rst),
        .tag_a_i       (tag_a),
        .tag_a_p_i     (tag_a_p),
        .tag_b_i       (tag_b),
        .tag_b_p_i     (tag_b_p),
        .pair_window_i (window),
        .phase_o       (phase),
        .phase_p_o     (phase_p),
        .period_o      (period),
        .period_p_o    (period_p),
        .orphan_cnt_o  (orphan_cnt),
        .avg_phase_o   (avg_phase),
        .avg_phase_p_o (avg_phase_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present pulses for one rising edge; returns on the next falling edge.
    task automatic drive(input logic ap, input logic [W-1:0] a,
                         input logic bp, input logic [W-1:0] b);
        tag_a_p = ap;
        tag_a   = a;
        tag_b_p = bp;
        tag_b   = b;
        @(negedge clk);
        tag_a_p = 1'b0;
        tag_b_p = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset state
        @(negedge clk);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_phase_p", 32'(phase_p), 32'h0);
        check("rst_period", 32'(period), 32'h0);
        check("rst_orphan", 32'(orphan_cnt), 32'h0);
        rst = 1'b0;

        // Simultaneous pulses; first A has no period
        drive(1'b1, 16'h0100, 1'b1, 16'h0140);
        check("sim_phase", 32'(phase), 32'h0040);
        check("sim_phase_p", 32'(phase_p), 32'h1);
        check("sim_period_p", 32'(period_p), 32'h0);
        check("sim_orphan", 32'(orphan_cnt), 32'h0);
        idle(1);
        check("sim_phase_p_drop", 32'(phase_p), 32'h0);

        // Wrap-around, A first
        window = 16'd8;
        drive(1'b1, 16'hFFFE, 1'b0, '0);
        check("wrap_period", 32'(period), 32'hFEFE);
        check("wrap_period_p", 32'(period_p), 32'h1);
        check("wrap_no_phase", 32'(phase_p), 32'h0);
        idle(2);
        drive(1'b0, '0, 1'b1, 16'h0003);
        check("wrap_phase", 32'(phase), 32'h0005);
        check("wrap_phase_p", 32'(phase_p), 32'h1);

        // B first, negative result
        drive(1'b0, '0, 1'b1, 16'h0010);
        idle(1);
        drive(1'b1, 16'h0020, 1'b0, '0);
        check("ba_phase", 32'(phase), 32'hFFF0);
        check("ba_phase_p", 32'(phase_p), 32'h1);
        check("ba_period", 32'(period), 32'h0022);
        check("ba_orphan", 32'(orphan_cnt), 32'h0);

        // Timeout with no partner
        do_reset();
        window = 16'd4;
        drive(1'b1, 16'h0100, 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (phase_p) seen = 1'b1;
        end
        check("to_no_phase", 32'(seen), 32'h0);
        check("to_orphan", 32'(orphan_cnt), 32'h1);

        // Partner on the timeout-check cycle pairs
        do_reset();
        window = 16'd4;
        drive(1'b1, 16'h0100, 1'b0, '0);
        idle(4);
        drive(1'b0, '0, 1'b1, 16'h0107);
        check("edge_phase", 32'(phase), 32'h0007);
        check("edge_phase_p", 32'(phase_p), 32'h1);
        check("edge_orphan", 32'(orphan_cnt), 32'h0);

        // Partner one cycle too late
        do_reset();
        window = 16'd4;
        drive(1'b1, 16'h0100, 1'b0, '0);
        idle(5);
        drive(1'b0, '0, 1'b1, 16'h0108);
        check("late_phase_p", 32'(phase_p), 32'h0);
        check("late_orphan", 32'(orphan_cnt), 32'h1);
        idle(6);
        check("late_b_orphan", 32'(orphan_cnt), 32'h2);

        // Window of zero: partner must be on the very next cycle
        do_reset();
        window = 16'd0;
        drive(1'b1, 16'h0200, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 16'h0203);
        check("w0_phase", 32'(phase), 32'h0003);
        check("w0_phase_p", 32'(phase_p), 32'h1);
        drive(1'b1, 16'h0300, 1'b0, '0);
        idle(1);
        drive(1'b0, '0, 1'b1, 16'h0305);
        check("w0_late_phase_p", 32'(phase_p), 32'h0);
        check("w0_late_orphan", 32'(orphan_cnt), 32'h1);

        // Double A, then B
        do_reset();
        window = 16'd8;
        drive(1'b1, 16'h1000, 1'b0, '0);
        drive(1'b1, 16'h1800, 1'b0, '0);
        check("dbl_orphan", 32'(orphan_cnt), 32'h1);
        check("dbl_period", 32'(period), 32'h0800);
        check("dbl_period_p", 32'(period_p), 32'h1);
        drive(1'b0, '0, 1'b1, 16'h1810);
        check("dbl_phase", 32'(phase), 32'h0010);
        check("dbl_phase_p", 32'(phase_p), 32'h1);

        // Asynchronous reset while A is pending
        drive(1'b1, 16'h0AAA, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        check("arst_phase", 32'(phase), 32'h0);
        check("arst_period", 32'(period), 32'h0);
        check("arst_orphan", 32'(orphan_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, 16'h0123);
        check("arst_b_no_phase", 32'(phase_p), 32'h0);
        drive(1'b1, 16'h0100, 1'b0, '0);
        check("arst_hb_phase", 32'(phase), 32'h0023);
        check("arst_hb_phase_p", 32'(phase_p), 32'h1);

`ifdef DDMTD_PHASE_AVG_EN
        // Average of 4, 8, -4, 0 is 2
        do_reset();
        seen = 1'b0;
        drive(1'b1, 16'h0000, 1'b1, 16'h0004);
        if (avg_phase_p) seen = 1'b1;
        drive(1'b1, 16'h0000, 1'b1, 16'h0008);
        if (avg_phase_p) seen = 1'b1;
        drive(1'b1, 16'h0000, 1'b1, 16'hFFFC);
        if (avg_phase_p) seen = 1'b1;
        drive(1'b1, 16'h0000, 1'b1, 16'h0000);
        if (avg_phase_p) seen = 1'b1;
        check("avg_early", 32'(seen), 32'h0);
        idle(1);
        check("avg_phase", 32'(avg_phase), 32'h0002);
        check("avg_phase_p", 32'(avg_phase_p), 32'h1);
        idle(1);
        check("avg_phase_p_drop", 32'(avg_phase_p), 32'h0);
`else
        check("avg_off", 32'(avg_phase), 32'h0);
        check("avg_off_p", 32'(avg_phase_p), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
